// File: rtl/io_arb_pkg.sv
// Shared types and constants for the two-requester I/O bus arbiter.
package io_arb_pkg;

  localparam int unsigned AW_DEFAULT = 23;
  localparam int unsigned DW         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Per-transfer control bits forwarded to the I/O bus master.
  typedef struct packed {
    logic rw;
    logic lds;
    logic uds;
  } io_ctl_t;

  localparam io_ctl_t IO_CTL_RESET = '{rw: 1'b1, lds: 1'b0, uds: 1'b0};

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Requester-side and I/O-master-side signals of the arbiter, bundled.
interface io_bus_arbiter_if #(
  parameter int unsigned AW = io_arb_pkg::AW_DEFAULT
) ();

  logic          R0REQ;
  logic          R0RW;
  logic          R0LDS;
  logic          R0UDS;
  logic [AW:1]   R0A;
  logic [15:0]   R0WD;
  logic          R0ACK;

  logic          R1REQ;
  logic          R1RW;
  logic          R1LDS;
  logic          R1UDS;
  logic [AW:1]   R1A;
  logic [15:0]   R1WD;
  logic          R1ACK;

  logic [15:0]   RD;
  logic [1:0]    GNT;

  logic          IOREQ;
  logic          IORW;
  logic          IOLDS;
  logic          IOUDS;
  logic [AW:1]   IOA;
  logic [15:0]   IOWD;
  logic          IOACT;
  logic          IODONE;
  logic [15:0]   IORD;

  // Arbiter side.
  modport slave (
    input  R0REQ, R0RW, R0LDS, R0UDS, R0A, R0WD,
    input  R1REQ, R1RW, R1LDS, R1UDS, R1A, R1WD,
    input  IOACT, IODONE, IORD,
    output R0ACK, R1ACK, RD, GNT,
    output IOREQ, IORW, IOLDS, IOUDS, IOA, IOWD
  );

  // Requesters plus I/O bus master side.
  modport master (
    output R0REQ, R0RW, R0LDS, R0UDS, R0A, R0WD,
    output R1REQ, R1RW, R1LDS, R1UDS, R1A, R1WD,
    output IOACT, IODONE, IORD,
    input  R0ACK, R1ACK, RD, GNT,
    input  IOREQ, IORW, IOLDS, IOUDS, IOA, IOWD
  );

endinterface

// File: rtl/io_bus_arbiter.sv
// Two-requester arbiter in front of a single I/O bus master.
// Round-robin or fixed R0 priority; one transfer in flight at a time.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned AW     = AW_DEFAULT,
  parameter int unsigned FIXPRI = 0
) (
  input  logic            C16M,
  input  logic            RES,
  io_bus_arbiter_if.slave bus
);

  localparam logic FIX = 1'(FIXPRI != 0);

  // One-hot winner; LAST=1 means R1 was the previous owner.
  function automatic logic [1:0] f_pick(input logic [1:0] elig,
                                        input logic       last,
                                        input logic       fix);
    logic [1:0] win;
    win = elig;
    if (elig == 2'b11) begin
      win = (fix || last) ? 2'b01 : 2'b10;
    end
    return win;
  endfunction

  arb_state_t  r_state;
  logic        r_last;
  logic [1:0]  r_gnt;
  logic        r_ioreq;
  io_ctl_t     r_ctl;
  logic [AW:1] r_ioa;
  logic [15:0] r_iowd;
  logic [15:0] r_rd;
  logic [1:0]  r_ack;

  arb_state_t  w_state;
  logic        w_last;
  logic [1:0]  w_gnt;
  logic        w_ioreq;
  io_ctl_t     w_ctl;
  logic [AW:1] w_ioa;
  logic [15:0] w_iowd;
  logic [15:0] w_rd;
  logic [1:0]  w_ack;
  logic [1:0]  w_elig;
  logic [1:0]  w_win;
  logic        w_io_idle;

  // Next-state and next-output logic.
  always_comb begin
    w_state   = r_state;
    w_last    = r_last;
    w_gnt     = r_gnt;
    w_ioreq   = r_ioreq;
    w_ctl     = r_ctl;
    w_ioa     = r_ioa;
    w_iowd    = r_iowd;
    w_rd      = r_rd;
    w_ack     = 2'b00;
    // A requester being acked this cycle must re-request to be seen again.
    w_elig    = {bus.R1REQ & ~r_ack[1], bus.R0REQ & ~r_ack[0]};
    w_win     = f_pick(w_elig, r_last, FIX);
    w_io_idle = ~bus.IOACT & ~bus.IODONE;

    unique case (r_state)
      IDLE: begin
        // Master must be fully idle, which also covers recovery after a reset mid-transfer.
        if (w_io_idle && (w_win != 2'b00)) begin
          w_gnt   = w_win;
          w_last  = w_win[1];
          w_ioreq = 1'b1;
          w_state = BUSY;
          if (w_win[1]) begin
            w_ctl  = '{rw: bus.R1RW, lds: bus.R1LDS, uds: bus.R1UDS};
            w_ioa  = bus.R1A;
            w_iowd = bus.R1WD;
          end else begin
            w_ctl  = '{rw: bus.R0RW, lds: bus.R0LDS, uds: bus.R0UDS};
            w_ioa  = bus.R0A;
            w_iowd = bus.R0WD;
          end
        end
      end
      BUSY: begin
        if (bus.IODONE) begin
          w_ioreq = 1'b0;
          w_state = DRAIN;
          if (r_ctl.rw) begin
            w_rd = bus.IORD;
          end
        end
      end
      DRAIN: begin
        if (w_io_idle) begin
          w_ack   = r_gnt;
          w_gnt   = 2'b00;
          w_state = IDLE;
        end
      end
      default: begin
        w_state = IDLE;
        w_ioreq = 1'b0;
        w_gnt   = 2'b00;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge C16M) begin
    if (RES) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gnt   <= 2'b00;
      r_ioreq <= 1'b0;
      r_ctl   <= IO_CTL_RESET;
      r_ioa   <= '0;
      r_iowd  <= '0;
      r_rd    <= '0;
      r_ack   <= 2'b00;
    end else begin
      r_state <= w_state;
      r_last  <= w_last;
      r_gnt   <= w_gnt;
      r_ioreq <= w_ioreq;
      r_ctl   <= w_ctl;
      r_ioa   <= w_ioa;
      r_iowd  <= w_iowd;
      r_rd    <= w_rd;
      r_ack   <= w_ack;
    end
  end

  assign bus.R0ACK = r_ack[0];
  assign bus.R1ACK = r_ack[1];
  assign bus.GNT   = r_gnt;
  assign bus.RD    = r_rd;
  assign bus.IOREQ = r_ioreq;
  assign bus.IORW  = r_ctl.rw;
  assign bus.IOLDS = r_ctl.lds;
  assign bus.IOUDS = r_ctl.uds;
  assign bus.IOA   = r_ioa;
  assign bus.IOWD  = r_iowd;

endmodule
